led_fade_pwm: RTL and testbench

- MMIO slot core that sits directly downstream of the 4-channel LED blinker slot.
- Consumes the blinker's on/off LED bits. Drives the board LED pins with per-channel PWM brightness and a linear fade-in/fade-out on every on/off transition.
- Software programs the peak brightness per channel, a shared fade rate, and an enable bit.
- When disabled, LED bits pass straight through.

---
 rtl/led_fade_pkg.sv | 15 +
 rtl/led_fade_pwm_if.sv | 14 +
 rtl/led_fade_channel.sv | 38 +++
 rtl/led_fade_pwm.sv | 82 ++++++++
 tb/tb_led_fade_pwm.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/led_fade_pkg.sv
// rtl/led_fade_pkg.sv - shared widths, level type and register addresses for the LED fade slot
package led_fade_pkg;

  localparam int PWM_BITS = 8;

  typedef logic [PWM_BITS-1:0] level_t;

  localparam logic [4:0] ADDR_DUTY_BASE = 5'd0;
  localparam logic [4:0] ADDR_FADE_DIV  = 5'd8;
  localparam logic [4:0] ADDR_CTRL      = 5'd9;
  localparam logic [4:0] ADDR_LEVELS    = 5'd10;

  localparam level_t LEVEL_MAX = '1;

endpackage

// File: rtl/led_fade_pwm_if.sv
// rtl/led_fade_pwm_if.sv - MMIO slot bus between the CPU fabric and the LED fade core
interface led_fade_pwm_if;

  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (output cs, read, write, addr, wr_data, input rd_data);
  modport slave  (input cs, read, write, addr, wr_data, output rd_data);

endinterface

// File: rtl/led_fade_channel.sv
// rtl/led_fade_channel.sv - one LED channel: linear level ramp toward target and PWM compare
module led_fade_channel #(
  parameter int PWM_BITS = led_fade_pkg::PWM_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fade_tick,
  input  logic                led_in,
  input  logic [PWM_BITS-1:0] max_duty,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                ctrl_en,
  output logic [PWM_BITS-1:0] level,
  output logic                led_out
);

  logic [PWM_BITS-1:0] target;
  logic                pwm_on;

  assign target = led_in ? max_duty : '0;
  // Full-scale level must be solid on, which a strict level > cnt compare cannot give.
  assign pwm_on = (level == '1) || (level > pwm_cnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      level   <= '0;
      led_out <= 1'b0;
    end else begin
      if (fade_tick) begin
        if (level < target)
          level <= level + 1'b1;
        else if (level > target)
          level <= level - 1'b1;
      end
      led_out <= ctrl_en ? pwm_on : led_in;
    end
  end

endmodule

// File: rtl/led_fade_pwm.sv
// rtl/led_fade_pwm.sv - LED fade slot top: register file, fade prescaler, PWM counter, channels
module led_fade_pwm #(
  parameter int N        = 4,
  parameter int PWM_BITS = led_fade_pkg::PWM_BITS
) (
  input  logic          clk,
  input  logic          reset,
  led_fade_pwm_if.slave bus,
  input  logic [N-1:0]  led_in,
  output logic [N-1:0]  led_out
);

  import led_fade_pkg::*;

  logic [N-1:0][PWM_BITS-1:0] max_duty;
  logic [N-1:0][PWM_BITS-1:0] level;
  logic [15:0]                fade_div;
  logic [15:0]                presc;
  logic [PWM_BITS-1:0]        pwm_cnt;
  logic                       ctrl_en;
  logic                       fade_tick;
  logic                       wr_en;
  logic                       unused_bits;

  assign wr_en       = bus.cs && bus.write;
  assign fade_tick   = (presc == fade_div);
  assign unused_bits = &{1'b0, bus.read, bus.wr_data[31:16]};

  always_ff @(posedge clk) begin
    if (reset) begin
      max_duty <= '0;
      fade_div <= '0;
      ctrl_en  <= 1'b0;
      presc    <= '0;
      pwm_cnt  <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      // A divider write restarts the fade period; a tick in that same cycle still lands.
      if ((wr_en && bus.addr == ADDR_FADE_DIV) || fade_tick)
        presc <= '0;
      else
        presc <= presc + 1'b1;
      if (wr_en) begin
        for (int i = 0; i < N; i++)
          if (bus.addr == 5'(ADDR_DUTY_BASE + i))
            max_duty[i] <= bus.wr_data[PWM_BITS-1:0];
        if (bus.addr == ADDR_FADE_DIV)
          fade_div <= bus.wr_data[15:0];
        if (bus.addr == ADDR_CTRL)
          ctrl_en <= bus.wr_data[0];
      end
    end
  end

  always_comb begin
    bus.rd_data = '0;
    for (int i = 0; i < N; i++)
      if (bus.addr == 5'(ADDR_DUTY_BASE + i))
        bus.rd_data = 32'(max_duty[i]);
    if (bus.addr == ADDR_FADE_DIV)
      bus.rd_data = {16'b0, fade_div};
    if (bus.addr == ADDR_CTRL)
      bus.rd_data = {31'b0, ctrl_en};
    if (bus.addr == ADDR_LEVELS)
      bus.rd_data = 32'(level);
  end

  for (genvar g = 0; g < N; g++) begin : g_ch
    led_fade_channel #(.PWM_BITS(PWM_BITS)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .fade_tick(fade_tick),
      .led_in   (led_in[g]),
      .max_duty (max_duty[g]),
      .pwm_cnt  (pwm_cnt),
      .ctrl_en  (ctrl_en),
      .level    (level[g]),
      .led_out  (led_out[g])
    );
  end

endmodule

// File: tb/tb_led_fade_pwm.sv
// tb/tb_led_fade_pwm.sv - directed bench with cycle-level reference model for led_fade_pwm
module tb_led_fade_pwm;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] led_in;
  logic [N-1:0] led_out;

  led_fade_pwm_if bus();

  led_fade_pwm #(.N(N)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .led_in (led_in),
    .led_out(led_out)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  bit chk_on = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
  endtask

  // Reference model: registers, fade phase and levels as plain integers.
  int           m_duty [N];
  int           m_level[N];
  int           m_div, m_en, m_phase, m_pwm;
  logic [N-1:0] m_led;

  always @(posedge clk) begin : model
    bit tick;
    int tgt;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_duty[i]  = 0;
        m_level[i] = 0;
      end
      m_div = 0; m_en = 0; m_phase = 0; m_pwm = 0; m_led = '0;
    end else begin
      tick = (m_phase == m_div);
      for (int i = 0; i < N; i++) begin
        tgt = led_in[i] ? m_duty[i] : 0;
        if (m_en != 0) m_led[i] = (m_level[i] == 255) || (m_level[i] > m_pwm);
        else           m_led[i] = led_in[i];
        if (tick) begin
          if (m_level[i] < tgt)      m_level[i] = m_level[i] + 1;
          else if (m_level[i] > tgt) m_level[i] = m_level[i] - 1;
        end
      end
      m_pwm   = (m_pwm + 1) % 256;
      m_phase = tick ? 0 : m_phase + 1;
      if (bus.cs && bus.write) begin
        if (bus.addr < N) m_duty[bus.addr] = int'(bus.wr_data & 32'hFF);
        else if (bus.addr == 8) begin
          m_div   = int'(bus.wr_data & 32'hFFFF);
          m_phase = 0;
        end else if (bus.addr == 9) m_en = int'(bus.wr_data & 32'h1);
      end
    end
  end

  function automatic logic [31:0] exp_rd(logic [4:0] a);
    logic [31:0] r = '0;
    if (a < N) r = m_duty[a];
    else if (a == 8) r = m_div;
    else if (a == 9) r = m_en;
    else if (a == 10)
      for (int i = 0; i < N; i++) r = r | (32'(m_level[i]) << (8 * i));
    return r;
  endfunction

  always @(posedge clk) begin : compare
    #1;
    if (chk_on) begin
      chk("led_out_model", {28'b0, led_out}, {28'b0, m_led});
      chk("rd_data_model", bus.rd_data, exp_rd(bus.addr));
    end
  end

  task automatic wr(logic [4:0] a, logic [31:0] d);
    @(negedge clk);
    bus.cs = 1'b1; bus.write = 1'b1; bus.addr = a; bus.wr_data = d;
    @(negedge clk);
    bus.cs = 1'b0; bus.write = 1'b0; bus.addr = 5'd10; bus.wr_data = '0;
  endtask

  task automatic rd_chk(string name, logic [4:0] a, logic [31:0] exp);
    @(negedge clk);
    bus.addr = a;
    #1 chk(name, bus.rd_data, exp);
    bus.addr = 5'd10;
  endtask

  task automatic cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic level_chk(string name, int ch, int exp);
    chk(name, 32'(bus.rd_data[ch*8 +: 8]), exp);
  endtask

  task automatic count_on(int ch, int n, output int ones);
    ones = 0;
    repeat (n) begin
      @(posedge clk); #1;
      ones += int'(led_out[ch]);
    end
  endtask

  task automatic wait_level(int ch, int val, int bound, string name);
    bit found = 1'b0;
    for (int k = 0; k < bound && !found; k++) begin
      @(posedge clk); #1;
      if (int'(bus.rd_data[ch*8 +: 8]) == val) found = 1'b1;
    end
    chk(name, 32'(found), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int ones;
    reset = 1'b1; led_in = '0;
    bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0; bus.addr = 5'd10; bus.wr_data = '0;
    @(posedge clk);
    chk_on = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    #1 chk("reset_led_out", {28'b0, led_out}, 32'd0);
    for (int a = 0; a <= 10; a++) rd_chk($sformatf("reset_rd_%0d", a), 5'(a), 32'd0);

    // Bypass
    @(negedge clk);
    led_in = 4'b1010;
    #1 chk("bypass_before_edge", {28'b0, led_out}, 32'd0);
    cycles(1);
    chk("bypass_one_cycle", {28'b0, led_out}, 32'b1010);
    @(negedge clk);
    led_in = 4'b0000;

    // Instant fade to 50 % duty
    wr(5'd0, 32'd128);
    wr(5'd9, 32'd1);
    led_in = 4'b0001;
    cycles(140);
    level_chk("instant_level0", 0, 128);
    count_on(0, 256, ones);
    chk("instant_duty_128", 32'(ones), 32'd128);

    // Ramp timing with a 10-cycle fade period
    wr(5'd1, 32'd20);
    wr(5'd8, 32'd9);
    led_in = 4'b0011;
    cycles(99);  level_chk("ramp_level_99", 1, 9);
    cycles(1);   level_chk("ramp_level_100", 1, 10);
    cycles(100); level_chk("ramp_level_200", 1, 20);
    cycles(50);  level_chk("ramp_hold_250", 1, 20);
    @(negedge clk);
    led_in = 4'b0001;
    cycles(199); level_chk("fall_level_199", 1, 1);
    cycles(1);   level_chk("fall_level_200", 1, 0);

    // Boundary levels and an unmapped write
    wr(5'd8, 32'd0);
    wr(5'd2, 32'd255);
    wr(5'd3, 32'd0);
    led_in = 4'b1101;
    cycles(260);
    level_chk("full_level2", 2, 255);
    count_on(2, 256, ones);
    chk("full_always_on", 32'(ones), 32'd256);
    count_on(3, 256, ones);
    chk("zero_always_off", 32'(ones), 32'd0);
    wr(5'd5, 32'hFFFF_FFFF);
    rd_chk("addr5_reads_zero", 5'd5, 32'd0);
    rd_chk("addr5_duty0", 5'd0, 32'd128);
    rd_chk("addr5_duty2", 5'd2, 32'd255);
    rd_chk("addr5_fade_div", 5'd8, 32'd0);
    rd_chk("addr5_ctrl", 5'd9, 32'd1);

    // Mid-ramp retarget, then reset at the new level
    wr(5'd8, 32'd3);
    wr(5'd1, 32'd200);
    led_in = 4'b1111;
    wait_level(1, 50, 1000, "mid_reach_50");
    wr(5'd1, 32'd30);
    wait_level(1, 30, 1000, "mid_reach_30");
    cycles(20);
    level_chk("mid_hold_30", 1, 30);
    @(negedge clk);
    reset = 1'b1;
    cycles(1);
    chk("reset_mid_levels", bus.rd_data, 32'd0);
    chk("reset_mid_led_out", {28'b0, led_out}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cycles(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
